// File: rtl/ysyx_23060332_wbu_pkg.sv
// Shared widths, load funct3 encodings and the write-back slot payload.
package ysyx_23060332_wbu_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned PC_W      = 32;
    localparam int unsigned INSTRET_W = 64;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic              wen;
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
        logic              err;
    } wb_slot_t;

endpackage

// File: rtl/ysyx_23060332_wbu_if.sv
// EXU/LSU result handshakes plus register-file and commit outputs of the WBU.
interface ysyx_23060332_wbu_if;
    import ysyx_23060332_wbu_pkg::*;

    logic                 exu_valid;
    logic                 exu_ready;
    logic [ADDR_W-1:0]    exu_rd;
    logic                 exu_wen;
    logic [DATA_W-1:0]    exu_result;
    logic [PC_W-1:0]      exu_pc;

    logic                 lsu_valid;
    logic                 lsu_ready;
    logic [ADDR_W-1:0]    lsu_rd;
    logic                 lsu_wen;
    logic [31:0]          lsu_rdata;
    logic [1:0]           lsu_addr_lo;
    logic [2:0]           lsu_funct3;
    logic [PC_W-1:0]      lsu_pc;

    logic [ADDR_W-1:0]    waddr;
    logic [DATA_W-1:0]    wdata;
    logic                 reg_wen;
    logic                 commit_valid;
    logic [PC_W-1:0]      commit_pc;
    logic                 wb_err;
    logic [INSTRET_W-1:0] instret;

    modport master (
        output exu_valid, exu_rd, exu_wen, exu_result, exu_pc,
        output lsu_valid, lsu_rd, lsu_wen, lsu_rdata, lsu_addr_lo, lsu_funct3, lsu_pc,
        input  exu_ready, lsu_ready,
        input  waddr, wdata, reg_wen, commit_valid, commit_pc, wb_err, instret
    );

    modport slave (
        input  exu_valid, exu_rd, exu_wen, exu_result, exu_pc,
        input  lsu_valid, lsu_rd, lsu_wen, lsu_rdata, lsu_addr_lo, lsu_funct3, lsu_pc,
        output exu_ready, lsu_ready,
        output waddr, wdata, reg_wen, commit_valid, commit_pc, wb_err, instret
    );

endinterface

// File: rtl/ysyx_23060332_load_ext.sv
// Combinational load formatter: selects byte/half/word from the raw word,
// extends it and flags misaligned or unsupported load types.
module ysyx_23060332_load_ext
    import ysyx_23060332_wbu_pkg::*;
(
    input  logic [31:0]       rdata,
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] data,
    output logic              err
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b    = rdata[{addr_lo, 3'b000} +: 8];
        h    = rdata[{addr_lo[1], 4'b0000} +: 16];
        data = '0;
        err  = 1'b0;
        unique case (funct3)
            F3_LB:   data = {{24{b[7]}}, b};
            F3_LBU:  data = {24'd0, b};
            F3_LH: begin
                err  = addr_lo[0];
                data = {{16{h[15]}}, h};
            end
            F3_LHU: begin
                err  = addr_lo[0];
                data = {16'd0, h};
            end
            F3_LW: begin
                err  = (addr_lo != 2'd0);
                data = rdata;
            end
            default: err = 1'b1;
        endcase
        // Faulting loads never leak partial data into the register file.
        if (err) begin
            data = '0;
        end
    end

endmodule

// File: rtl/ysyx_23060332_wbu.sv
// Write-back unit: LSU-priority arbiter, single result slot driving the
// register-file write port and commit pulse, and the retired-instruction counter.
module ysyx_23060332_wbu
    import ysyx_23060332_wbu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    ysyx_23060332_wbu_if.slave  wb
);

    logic [DATA_W-1:0]    ext_data;
    logic                 ext_err;
    logic                 lsu_err;
    logic                 accept_lsu;
    logic                 accept_exu;

    wb_slot_t             slot_d, slot_q;
    logic                 slot_v_d, slot_v_q;
    logic                 reg_wen_d, reg_wen_q;
    logic [INSTRET_W-1:0] instret_d, instret_q;

    ysyx_23060332_load_ext u_load_ext (
        .rdata   (wb.lsu_rdata),
        .addr_lo (wb.lsu_addr_lo),
        .funct3  (wb.lsu_funct3),
        .data    (ext_data),
        .err     (ext_err)
    );

    assign wb.lsu_ready = ~stall;
    assign wb.exu_ready = ~stall & ~wb.lsu_valid;

    always_comb begin
        accept_lsu = wb.lsu_valid & ~stall;
        accept_exu = wb.exu_valid & ~stall & ~wb.lsu_valid;
        // Stores (wen=0) never raise a load-format error.
        lsu_err    = wb.lsu_wen & ext_err;

        slot_d    = slot_q;
        slot_v_d  = 1'b0;
        reg_wen_d = 1'b0;
        instret_d = instret_q + INSTRET_W'(slot_v_q);

        if (accept_lsu) begin
            slot_d.rd   = wb.lsu_rd;
            slot_d.wen  = wb.lsu_wen & ~lsu_err;
            slot_d.data = ext_data;
            slot_d.pc   = wb.lsu_pc;
            slot_d.err  = lsu_err;
            slot_v_d    = 1'b1;
        end else if (accept_exu) begin
            slot_d.rd   = wb.exu_rd;
            slot_d.wen  = wb.exu_wen;
            slot_d.data = wb.exu_result;
            slot_d.pc   = wb.exu_pc;
            slot_d.err  = 1'b0;
            slot_v_d    = 1'b1;
        end

        // x0 writes still retire but never reach the register file.
        reg_wen_d = slot_v_d & slot_d.wen & (slot_d.rd != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q    <= '0;
            slot_v_q  <= 1'b0;
            reg_wen_q <= 1'b0;
            instret_q <= '0;
        end else begin
            slot_q    <= slot_d;
            slot_v_q  <= slot_v_d;
            reg_wen_q <= reg_wen_d;
            instret_q <= instret_d;
        end
    end

    assign wb.waddr        = slot_q.rd;
    assign wb.wdata        = slot_q.data;
    assign wb.commit_pc    = slot_q.pc;
    assign wb.reg_wen      = reg_wen_q;
    assign wb.commit_valid = slot_v_q;
    assign wb.wb_err       = slot_v_q & slot_q.err;
    assign wb.instret      = instret_q;

endmodule

// File: tb/tb_ysyx_23060332_wbu.sv
// Directed self-checking bench for the write-back unit.
module tb_ysyx_23060332_wbu;

    logic clk;
    logic rst_n;
    logic stall;
    int   n_checks;
    int   n_errors;

    ysyx_23060332_wbu_if wbif ();

    ysyx_23060332_wbu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall),
        .wb    (wbif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exu(input logic v, input logic [4:0] rd, input logic wen,
                           input logic [31:0] res, input logic [31:0] pc);
        wbif.exu_valid  = v;
        wbif.exu_rd     = rd;
        wbif.exu_wen    = wen;
        wbif.exu_result = res;
        wbif.exu_pc     = pc;
    endtask

    task automatic set_lsu(input logic v, input logic [4:0] rd, input logic wen,
                           input logic [31:0] rdata, input logic [1:0] lo,
                           input logic [2:0] f3, input logic [31:0] pc);
        wbif.lsu_valid   = v;
        wbif.lsu_rd      = rd;
        wbif.lsu_wen     = wen;
        wbif.lsu_rdata   = rdata;
        wbif.lsu_addr_lo = lo;
        wbif.lsu_funct3  = f3;
        wbif.lsu_pc      = pc;
    endtask

    task automatic check_commit(input string tag, input logic [4:0] addr, input logic [31:0] data,
                                input logic wen, input logic err, input logic [31:0] pc);
        check({tag, ".commit_valid"}, 64'(wbif.commit_valid), 64'd1);
        check({tag, ".reg_wen"},      64'(wbif.reg_wen),      64'(wen));
        check({tag, ".wb_err"},       64'(wbif.wb_err),       64'(err));
        check({tag, ".commit_pc"},    64'(wbif.commit_pc),    64'(pc));
        if (wen) begin
            check({tag, ".waddr"}, 64'(wbif.waddr), 64'(addr));
            check({tag, ".wdata"}, 64'(wbif.wdata), 64'(data));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        stall    = 1'b0;
        set_exu(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        set_lsu(1'b0, 5'd0, 1'b0, 32'd0, 2'd0, 3'd0, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        check("rst.commit_valid", 64'(wbif.commit_valid), 64'd0);
        check("rst.reg_wen",      64'(wbif.reg_wen),      64'd0);
        check("rst.wdata",        64'(wbif.wdata),        64'd0);
        check("rst.instret",      wbif.instret,           64'd0);
        check("rst.exu_ready",    64'(wbif.exu_ready),    64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // EXU alone
        set_exu(1'b1, 5'd5, 1'b1, 32'hDEADBEEF, 32'h8000_0000);
        #1;
        check("exu.ready", 64'(wbif.exu_ready), 64'd1);
        cyc();
        set_exu(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        check_commit("exu", 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 32'h8000_0000);
        cyc();
        check("exu.drain", 64'(wbif.commit_valid), 64'd0);
        check("exu.instret", wbif.instret, 64'd1);

        // Back-to-back loads: LB, LBU, LH, misaligned LW
        set_lsu(1'b1, 5'd1, 1'b1, 32'h80FF7F01, 2'd2, 3'd0, 32'h100);
        cyc();
        check_commit("lb", 5'd1, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h100);
        set_lsu(1'b1, 5'd2, 1'b1, 32'h80FF7F01, 2'd2, 3'd4, 32'h104);
        cyc();
        check_commit("lbu", 5'd2, 32'h000000FF, 1'b1, 1'b0, 32'h104);
        set_lsu(1'b1, 5'd4, 1'b1, 32'h80FF7F01, 2'd2, 3'd1, 32'h108);
        cyc();
        check_commit("lh", 5'd4, 32'hFFFF80FF, 1'b1, 1'b0, 32'h108);
        set_lsu(1'b1, 5'd3, 1'b1, 32'h80FF7F01, 2'd1, 3'd2, 32'h10C);
        cyc();
        check_commit("lw_mis", 5'd3, 32'd0, 1'b0, 1'b1, 32'h10C);
        set_lsu(1'b1, 5'd6, 1'b1, 32'h80FF7F01, 2'd1, 3'd5, 32'h110);
        cyc();
        check_commit("lhu_mis", 5'd6, 32'd0, 1'b0, 1'b1, 32'h110);
        set_lsu(1'b1, 5'd6, 1'b1, 32'h12345678, 2'd0, 3'd3, 32'h114);
        cyc();
        check_commit("f3_3", 5'd6, 32'd0, 1'b0, 1'b1, 32'h114);
        // Store: no write, no error even though offset is misaligned
        set_lsu(1'b1, 5'd7, 1'b0, 32'h12345678, 2'd1, 3'd2, 32'h118);
        cyc();
        check_commit("store", 5'd7, 32'd0, 1'b0, 1'b0, 32'h118);
        set_lsu(1'b0, 5'd0, 1'b0, 32'd0, 2'd0, 3'd0, 32'd0);
        cyc();
        check("loads.instret", wbif.instret, 64'd8);

        // Both valid: LSU wins, EXU holds and follows
        set_exu(1'b1, 5'd7, 1'b1, 32'h0000_1234, 32'h200);
        set_lsu(1'b1, 5'd8, 1'b1, 32'h0000_00AB, 2'd0, 3'd4, 32'h204);
        #1;
        check("arb.exu_ready", 64'(wbif.exu_ready), 64'd0);
        check("arb.lsu_ready", 64'(wbif.lsu_ready), 64'd1);
        cyc();
        set_lsu(1'b0, 5'd0, 1'b0, 32'd0, 2'd0, 3'd0, 32'd0);
        check_commit("arb_lsu", 5'd8, 32'h0000_00AB, 1'b1, 1'b0, 32'h204);
        #1;
        check("arb.exu_ready2", 64'(wbif.exu_ready), 64'd1);
        cyc();
        set_exu(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        check_commit("arb_exu", 5'd7, 32'h0000_1234, 1'b1, 1'b0, 32'h200);

        // x0 destination commits without writing
        set_exu(1'b1, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'h300);
        cyc();
        set_exu(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        check_commit("x0", 5'd0, 32'd0, 1'b0, 1'b0, 32'h300);
        cyc();
        check("x0.instret", wbif.instret, 64'd11);

        // Stall blocks acceptance, release lets the held result through
        stall = 1'b1;
        set_exu(1'b1, 5'd9, 1'b1, 32'hCAFE_0001, 32'h400);
        #1;
        check("stall.exu_ready", 64'(wbif.exu_ready), 64'd0);
        check("stall.lsu_ready", 64'(wbif.lsu_ready), 64'd0);
        cyc();
        check("stall.commit", 64'(wbif.commit_valid), 64'd0);
        stall = 1'b0;
        cyc();
        set_exu(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        check_commit("unstall", 5'd9, 32'hCAFE_0001, 1'b1, 1'b0, 32'h400);

        // Asynchronous reset while the slot holds a result
        set_exu(1'b1, 5'd10, 1'b1, 32'h0000_0055, 32'h500);
        cyc();
        set_exu(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        check("prerst.commit", 64'(wbif.commit_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.commit",    64'(wbif.commit_valid), 64'd0);
        check("midrst.reg_wen",   64'(wbif.reg_wen),      64'd0);
        check("midrst.waddr",     64'(wbif.waddr),        64'd0);
        check("midrst.wdata",     64'(wbif.wdata),        64'd0);
        check("midrst.commit_pc", 64'(wbif.commit_pc),    64'd0);
        check("midrst.wb_err",    64'(wbif.wb_err),       64'd0);
        check("midrst.instret",   wbif.instret,           64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_exu(1'b1, 5'd11, 1'b1, 32'h0000_0077, 32'h600);
        cyc();
        set_exu(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        check_commit("postrst", 5'd11, 32'h0000_0077, 1'b1, 1'b0, 32'h600);
        cyc();
        check("postrst.instret", wbif.instret, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
